// File: rtl/col_sched_if.sv
// Column scheduler bus: theta input, column stream handshake and mask outputs.
// The scheduler uses the slave side; its driver uses the master side.
interface col_sched_if #(
  parameter int THETA_RES = 27,
  parameter int NUM_COLS  = 64
);
  localparam int CW = $clog2(NUM_COLS);

  logic [THETA_RES-1:0] theta_in;
  logic                 theta_valid_in;
  logic [NUM_COLS-1:0]  col_mask_out;
  logic                 mask_valid_out;
  logic [CW-1:0]        sector_out;
  logic [CW-1:0]        col_idx_out;
  logic                 col_valid_out;
  logic                 col_ready_in;
  logic                 col_last_out;
  logic                 busy_out;

  modport master (
    output theta_in, theta_valid_in, col_ready_in,
    input  col_mask_out, mask_valid_out, sector_out,
    input  col_idx_out, col_valid_out, col_last_out, busy_out
  );

  modport slave (
    input  theta_in, theta_valid_in, col_ready_in,
    output col_mask_out, mask_valid_out, sector_out,
    output col_idx_out, col_valid_out, col_last_out, busy_out
  );
endinterface

// File: rtl/col_sched.sv
// Sector-driven column window scheduler with back-pressured index stream.
// Define COL_SCHED_ALL_COLS_EN to stream every column on each sector change.
module col_sched #(
  parameter int THETA_RES = 27,
  parameter int NUM_COLS  = 64,
  parameter int WINDOW    = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  col_sched_if.slave bus
);
  localparam int CW = $clog2(NUM_COLS);
`ifdef COL_SCHED_ALL_COLS_EN
  localparam int EFF_W = NUM_COLS;
`else
  localparam int EFF_W = WINDOW;
`endif
  localparam logic [CW-1:0] HALF     = CW'(EFF_W / 2);
  localparam logic [CW:0]   LAST_CNT = (CW+1)'(EFF_W - 1);
  localparam logic [CW:0]   W_CMP    = (CW+1)'(EFF_W);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t               r_state;
  state_t               w_nxt_state;
  logic                 r_seen;
  logic [CW-1:0]        r_last_sec;
  logic                 r_pend_vld;
  logic [CW-1:0]        r_pend_sec;
  logic [CW-1:0]        r_sector;
  logic [NUM_COLS-1:0]  r_mask;
  logic                 r_mask_valid;
  logic [CW:0]          r_count;
  logic [CW-1:0]        r_idx;
  logic                 r_col_valid;
  logic                 r_col_last;

  logic [CW-1:0]        w_sec;
  logic                 w_acc;
  logic                 w_hs;
  logic                 w_done;
  logic                 w_load;
  logic [CW-1:0]        w_load_sec;
  logic [CW-1:0]        w_start;
  logic [NUM_COLS-1:0]  w_mask;
  logic [CW-1:0]        w_d;
  logic                 w_unused;

  assign w_unused = ^bus.theta_in[THETA_RES-CW-1:0];
  assign w_sec    = bus.theta_in[THETA_RES-1 -: CW];
  assign w_acc    = bus.theta_valid_in &&
                    (!r_seen || (w_sec != r_last_sec));
  assign w_hs     = r_col_valid && bus.col_ready_in;
  assign w_done   = w_hs && r_col_last;

  // Incoming theta takes priority over anything held in pending.
  assign w_load_sec = w_acc ? w_sec : r_pend_sec;

`ifdef COL_SCHED_ALL_COLS_EN
  assign w_start = '0;
`else
  assign w_start = w_load_sec - HALF;
`endif

  always_comb begin
    w_mask = '0;
    w_d    = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      w_d       = CW'(i) - w_start;
      w_mask[i] = ({1'b0, w_d} < W_CMP);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_load      = 1'b1;
          w_nxt_state = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_done) begin
          if (w_acc || r_pend_vld) begin
            w_load = 1'b1;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_seen       <= 1'b0;
      r_last_sec   <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_sec   <= '0;
      r_sector     <= '0;
      r_mask       <= '0;
      r_mask_valid <= 1'b0;
      r_count      <= '0;
      r_idx        <= '0;
      r_col_valid  <= 1'b0;
      r_col_last   <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_mask_valid <= w_load;
      if (w_acc) begin
        r_seen     <= 1'b1;
        r_last_sec <= w_sec;
      end
      if (w_load) begin
        r_pend_vld  <= 1'b0;
        r_sector    <= w_load_sec;
        r_mask      <= w_mask;
        r_count     <= '0;
        r_idx       <= w_start;
        r_col_valid <= 1'b1;
        r_col_last  <= (LAST_CNT == '0);
      end else begin
        if (w_acc && (r_state == S_STREAM)) begin
          r_pend_vld <= 1'b1;
          r_pend_sec <= w_sec;
        end
        if (w_done) begin
          r_col_valid <= 1'b0;
          r_col_last  <= 1'b0;
        end else if (w_hs) begin
          r_count    <= r_count + 1'b1;
          r_idx      <= r_idx + 1'b1;
          r_col_last <= ((r_count + 1'b1) == LAST_CNT);
        end
      end
    end
  end

  assign bus.col_mask_out   = r_mask;
  assign bus.mask_valid_out = r_mask_valid;
  assign bus.sector_out     = r_sector;
  assign bus.col_idx_out    = r_idx;
  assign bus.col_valid_out  = r_col_valid;
  assign bus.col_last_out   = r_col_last;
  assign bus.busy_out       = (r_state == S_STREAM);
endmodule
